// File: rtl/mx_tile_pkg.sv
// mx_tile_pkg: definitions shared by the matmul tile loader and its row buffers.
//   tile_state_e : tile loader FSM states (LOAD collects beats, FULL presents the tile).
//   elem_t/scale_t : default element and shared-scale containers.
//   block_idx()  : maps a row index to the MX block that contains it.
package mx_tile_pkg;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    FULL = 1'b1
  } tile_state_e;

  localparam int unsigned BIT_WIDTH   = 8;
  localparam int unsigned SCALE_WIDTH = 8;

  typedef logic [BIT_WIDTH-1:0]   elem_t;
  typedef logic [SCALE_WIDTH-1:0] scale_t;

  // Block that holds a given row when blocks are blk_size rows tall.
  function automatic int unsigned block_idx(input int unsigned row, input int unsigned blk_size);
    return row / blk_size;
  endfunction

endpackage

// File: rtl/matmul_tile_loader_tile_row_buffer.sv
// tile_row_buffer: collects up to depth row beats over a valid/ready stream.
//   clk, rst_n        : clock, synchronous active-low reset
//   load_en           : the owning FSM is collecting beats
//   clear             : restart the row counter (tile handed off)
//   valid/ready       : row beat handshake; ready depends on registered state only
//   row, scale        : beat payload; scale is captured every stride-th row
//   full_next         : all rows are in once this cycle's beat (if any) lands
//   rows, scales      : registered storage, held until overwritten
module tile_row_buffer
  import mx_tile_pkg::*;
#(
  parameter int unsigned depth   = 4,
  parameter int unsigned row_w   = 64,
  parameter int unsigned scale_w = 32,
  parameter int unsigned stride  = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                load_en,
  input  logic                                clear,
  input  logic                                valid,
  output logic                                ready,
  input  logic [row_w-1:0]                    row,
  input  logic [scale_w-1:0]                  scale,
  output logic                                full_next,
  output logic [depth-1:0][row_w-1:0]         rows,
  output logic [depth/stride-1:0][scale_w-1:0] scales
);

  localparam int unsigned cw     = $clog2(depth + 1);
  localparam int unsigned sdepth = depth / stride;
  localparam int unsigned iw     = (depth > 1) ? $clog2(depth) : 1;
  localparam int unsigned siw    = (sdepth > 1) ? $clog2(sdepth) : 1;

  logic [cw-1:0]                     cnt_r;
  logic [depth-1:0][row_w-1:0]       rows_r;
  logic [sdepth-1:0][scale_w-1:0]    scales_r;
  logic                              accept_s;
  logic                              scale_we_s;
  logic [iw-1:0]                     row_idx_s;
  logic [siw-1:0]                    scale_idx_s;

  // The counter saturates at depth, which is what drops ready.
  assign ready       = load_en && (cnt_r < cw'(depth));
  assign accept_s    = valid && ready;
  assign row_idx_s   = cnt_r[iw-1:0];
  // Only the first row of each block carries the block's scale.
  assign scale_we_s  = accept_s && ((32'(cnt_r) % stride) == 32'd0);
  assign scale_idx_s = siw'(block_idx(32'(cnt_r), stride));
  assign full_next   = (cnt_r == cw'(depth)) || (accept_s && (cnt_r == cw'(depth - 1)));
  assign rows        = rows_r;
  assign scales      = scales_r;

  // Row counter and row/scale storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r    <= '0;
      rows_r   <= '0;
      scales_r <= '0;
    end else begin
      if (clear) begin
        cnt_r <= '0;
      end else if (accept_s) begin
        cnt_r <= cnt_r + cw'(1);
      end
      if (accept_s) begin
        rows_r[row_idx_s] <= row;
      end
      if (scale_we_s) begin
        scales_r[scale_idx_s] <= scale;
      end
    end
  end

endmodule

// File: rtl/matmul_tile_loader.sv
// matmul_tile_loader: staging buffer that assembles one A/B/S_A/S_B tile for
// matmul_fp from two independent row streams and presents it under valid/ready.
//   i_clk, i_rst_n              : clock, synchronous active-low reset
//   i_a_valid/o_a_ready, i_a_row, i_s_a_row : A row stream with per-block A scales
//   i_b_valid/o_b_ready, i_b_row, i_s_b_row : B row stream with block B scales
//   o_tile_valid/i_tile_ready   : tile handshake
//   o_A, o_B, o_S_A, o_S_B      : registered tile arrays, stable while o_tile_valid
module matmul_tile_loader
  import mx_tile_pkg::*;
#(
  parameter  int unsigned x_rows         = 4,
  parameter  int unsigned vec_elem_count = 8,
  parameter  int unsigned y_cols         = 2,
  parameter  int unsigned k              = 2,
  parameter  int unsigned bit_width      = 8,
  parameter  int unsigned scale_width    = 8,
  localparam int unsigned block_count    = vec_elem_count / k
) (
  input  logic                                                    i_clk,
  input  logic                                                    i_rst_n,
  input  logic                                                    i_a_valid,
  output logic                                                    o_a_ready,
  input  logic [vec_elem_count-1:0][bit_width-1:0]                i_a_row,
  input  logic [block_count-1:0][scale_width-1:0]                 i_s_a_row,
  input  logic                                                    i_b_valid,
  output logic                                                    o_b_ready,
  input  logic [y_cols-1:0][bit_width-1:0]                        i_b_row,
  input  logic [y_cols-1:0][scale_width-1:0]                      i_s_b_row,
  output logic                                                    o_tile_valid,
  input  logic                                                    i_tile_ready,
  output logic [x_rows-1:0][vec_elem_count-1:0][bit_width-1:0]    o_A,
  output logic [vec_elem_count-1:0][y_cols-1:0][bit_width-1:0]    o_B,
  output logic [x_rows-1:0][block_count-1:0][scale_width-1:0]     o_S_A,
  output logic [block_count-1:0][y_cols-1:0][scale_width-1:0]     o_S_B
);

  if ((vec_elem_count % k) != 0) begin : g_bad_k
    $error("matmul_tile_loader: k must divide vec_elem_count");
  end

  tile_state_e state_r;
  tile_state_e state_next_s;
  logic        tile_valid_r;
  logic        tile_take_s;
  logic        load_en_s;
  logic        a_full_next_s;
  logic        b_full_next_s;

  assign load_en_s    = (state_r == LOAD);
  assign o_tile_valid = tile_valid_r;

  tile_row_buffer #(
    .depth   (x_rows),
    .row_w   (vec_elem_count * bit_width),
    .scale_w (block_count * scale_width),
    .stride  (1)
  ) u_a_buf (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .load_en   (load_en_s),
    .clear     (tile_take_s),
    .valid     (i_a_valid),
    .ready     (o_a_ready),
    .row       (i_a_row),
    .scale     (i_s_a_row),
    .full_next (a_full_next_s),
    .rows      (o_A),
    .scales    (o_S_A)
  );

  tile_row_buffer #(
    .depth   (vec_elem_count),
    .row_w   (y_cols * bit_width),
    .scale_w (y_cols * scale_width),
    .stride  (k)
  ) u_b_buf (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .load_en   (load_en_s),
    .clear     (tile_take_s),
    .valid     (i_b_valid),
    .ready     (o_b_ready),
    .row       (i_b_row),
    .scale     (i_s_b_row),
    .full_next (b_full_next_s),
    .rows      (o_B),
    .scales    (o_S_B)
  );

  // Next state: fill completes counting this cycle's beats; FULL waits for the consumer.
  always_comb begin
    state_next_s = state_r;
    tile_take_s  = 1'b0;
    case (state_r)
      LOAD: begin
        if (a_full_next_s && b_full_next_s) begin
          state_next_s = FULL;
        end else begin
          state_next_s = LOAD;
        end
      end
      FULL: begin
        if (i_tile_ready) begin
          state_next_s = LOAD;
          tile_take_s  = 1'b1;
        end else begin
          state_next_s = FULL;
        end
      end
      default: begin
        state_next_s = LOAD;
      end
    endcase
  end

  // State register and registered tile-valid flag.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r      <= LOAD;
      tile_valid_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      tile_valid_r <= (state_next_s == FULL);
    end
  end

endmodule

// File: tb/tb_matmul_tile_loader.sv
// tb_matmul_tile_loader: directed self-checking bench for matmul_tile_loader
// (default parameters plus a k=4 instance for the scale-stride case).
module tb_matmul_tile_loader;

  localparam int unsigned X = 4, V = 8, Y = 2, K = 2, BW = 8, SW = 8;
  localparam int unsigned BC = V / K;
  localparam int unsigned K4 = 4;
  localparam int unsigned BC4 = V / K4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, a_valid, a_ready, b_valid, b_ready, tile_valid, tile_ready;
  logic [V-1:0][BW-1:0]      a_row;
  logic [BC-1:0][SW-1:0]     s_a_row;
  logic [Y-1:0][BW-1:0]      b_row;
  logic [Y-1:0][SW-1:0]      s_b_row;
  logic [X-1:0][V-1:0][BW-1:0]  o_A;
  logic [V-1:0][Y-1:0][BW-1:0]  o_B;
  logic [X-1:0][BC-1:0][SW-1:0] o_S_A;
  logic [BC-1:0][Y-1:0][SW-1:0] o_S_B;

  logic [X-1:0][V-1:0][BW-1:0]  exp_A;
  logic [V-1:0][Y-1:0][BW-1:0]  exp_B;
  logic [X-1:0][BC-1:0][SW-1:0] exp_S_A;
  logic [BC-1:0][Y-1:0][SW-1:0] exp_S_B;

  logic k4_a_valid, k4_a_ready, k4_b_valid, k4_b_ready, k4_tile_valid;
  logic [V-1:0][BW-1:0]          k4_a_row;
  logic [BC4-1:0][SW-1:0]        k4_s_a_row;
  logic [Y-1:0][BW-1:0]          k4_b_row;
  logic [Y-1:0][SW-1:0]          k4_s_b_row;
  logic [X-1:0][V-1:0][BW-1:0]   k4_o_A;
  logic [V-1:0][Y-1:0][BW-1:0]   k4_o_B;
  logic [X-1:0][BC4-1:0][SW-1:0] k4_o_S_A;
  logic [BC4-1:0][Y-1:0][SW-1:0] k4_o_S_B;

  int n_checks = 0;
  int n_errors = 0;

  matmul_tile_loader #(.x_rows(X), .vec_elem_count(V), .y_cols(Y), .k(K),
                       .bit_width(BW), .scale_width(SW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_valid(a_valid), .o_a_ready(a_ready), .i_a_row(a_row), .i_s_a_row(s_a_row),
    .i_b_valid(b_valid), .o_b_ready(b_ready), .i_b_row(b_row), .i_s_b_row(s_b_row),
    .o_tile_valid(tile_valid), .i_tile_ready(tile_ready),
    .o_A(o_A), .o_B(o_B), .o_S_A(o_S_A), .o_S_B(o_S_B)
  );

  matmul_tile_loader #(.x_rows(X), .vec_elem_count(V), .y_cols(Y), .k(K4),
                       .bit_width(BW), .scale_width(SW)) dut_k4 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_valid(k4_a_valid), .o_a_ready(k4_a_ready), .i_a_row(k4_a_row), .i_s_a_row(k4_s_a_row),
    .i_b_valid(k4_b_valid), .o_b_ready(k4_b_ready), .i_b_row(k4_b_row), .i_s_b_row(k4_s_b_row),
    .o_tile_valid(k4_tile_valid), .i_tile_ready(1'b0),
    .o_A(k4_o_A), .o_B(k4_o_B), .o_S_A(k4_o_S_A), .o_S_B(k4_o_S_B)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  // A[r][c] = be + 8r + c, S_A[r][blk] = bs + 16r + blk
  task automatic drive_a(input int r, input int be, input int bs);
    a_valid = 1'b1;
    for (int c = 0; c < int'(V); c++) a_row[c] = 8'(be + 8 * r + c);
    for (int b = 0; b < int'(BC); b++) s_a_row[b] = 8'(bs + 16 * r + b);
  endtask

  // B[r][c] = be + 2r + c, both scale columns = bs + r
  task automatic drive_b(input int r, input int be, input int bs);
    b_valid = 1'b1;
    for (int c = 0; c < int'(Y); c++) begin
      b_row[c]   = 8'(be + 2 * r + c);
      s_b_row[c] = 8'(bs + r);
    end
  endtask

  // Expected tile; B scales come only from rows 0, K, 2K, ...
  task automatic build_exp(input int ae, input int as, input int be, input int bs);
    for (int r = 0; r < int'(X); r++) begin
      for (int c = 0; c < int'(V); c++) exp_A[r][c] = 8'(ae + 8 * r + c);
      for (int b = 0; b < int'(BC); b++) exp_S_A[r][b] = 8'(as + 16 * r + b);
    end
    for (int r = 0; r < int'(V); r++)
      for (int c = 0; c < int'(Y); c++) exp_B[r][c] = 8'(be + 2 * r + c);
    for (int b = 0; b < int'(BC); b++)
      for (int c = 0; c < int'(Y); c++) exp_S_B[b][c] = 8'(bs + b * K);
  endtask

  task automatic check_tile(input string tag);
    check({tag, "_A"}, o_A, exp_A);
    check({tag, "_B"}, o_B, exp_B);
    check({tag, "_SA"}, o_S_A, exp_S_A);
    check({tag, "_SB"}, o_S_B, exp_S_B);
  endtask

  initial begin
    rst_n = 1'b0; tile_ready = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    a_row = '0; s_a_row = '0; b_row = '0; s_b_row = '0;
    k4_a_valid = 1'b0; k4_b_valid = 1'b0;
    k4_a_row = '0; k4_s_a_row = '0; k4_b_row = '0; k4_s_b_row = '0;
    tick();
    tick();
    check("rst_tile_valid", tile_valid, 1'b0);
    check("rst_a_ready", a_ready, 1'b1);
    check("rst_b_ready", b_ready, 1'b1);
    check("rst_A", o_A, '0);
    check("rst_B", o_B, '0);
    check("rst_SA", o_S_A, '0);
    check("rst_SB", o_S_B, '0);
    rst_n = 1'b1;

    // Tile 1: all A rows, then all B rows.
    for (int r = 0; r < 4; r++) begin
      drive_a(r, 0, 0);
      check("t1_a_ready", a_ready, 1'b1);
      tick();
    end
    idle();
    check("t1_a_sat", a_ready, 1'b0);
    check("t1_b_ready", b_ready, 1'b1);
    check("t1_valid_early", tile_valid, 1'b0);
    for (int r = 0; r < 8; r++) begin
      drive_b(r, 0, 8'h40);
      if (r == 7) check("t1_valid_last", tile_valid, 1'b0);
      tick();
    end
    idle();
    check("t1_valid", tile_valid, 1'b1);
    check("t1_a_ready_full", a_ready, 1'b0);
    check("t1_b_ready_full", b_ready, 1'b0);
    check("t1_A25", o_A[2][5], 8'd21);
    check("t1_SB_const", o_S_B, 64'h4646_4444_4242_4040);
    build_exp(0, 0, 0, 8'h40);
    check_tile("t1");

    // Hold FULL with junk on both streams.
    a_valid = 1'b1; b_valid = 1'b1;
    a_row = '1; s_a_row = '1; b_row = '1; s_b_row = '1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_a_ready", a_ready, 1'b0);
      check("hold_b_ready", b_ready, 1'b0);
      check("hold_valid", tile_valid, 1'b1);
      check_tile("hold");
    end

    // Handshake pulse.
    idle();
    tile_ready = 1'b1;
    tick();
    tile_ready = 1'b0;
    check("hs_valid", tile_valid, 1'b0);
    check("hs_a_ready", a_ready, 1'b1);
    check("hs_b_ready", b_ready, 1'b1);
    check("hs_A_kept", o_A, exp_A);

    // Tile 2: interleaved, last A and last B in the same cycle.
    for (int i = 0; i < 8; i++) begin
      drive_b(i, 8'h60, 8'h50);
      if (i >= 4) drive_a(i - 4, 8'h80, 8'hA0);
      else a_valid = 1'b0;
      if (i == 7) check("t2_valid_last", tile_valid, 1'b0);
      tick();
    end
    a_row = '1; s_a_row = '1; b_row = '1; s_b_row = '1;
    check("t2_valid", tile_valid, 1'b1);
    check("t2_a_ready", a_ready, 1'b0);
    check("t2_b_ready", b_ready, 1'b0);
    tick();
    idle();
    build_exp(8'h80, 8'hA0, 8'h60, 8'h50);
    check_tile("t2");
    check("t2_A00", o_A[0][0], 8'h80);

    // Partial load (tile_ready held high in LOAD is ignored), then reset.
    tile_ready = 1'b1;
    tick();
    drive_a(0, 8'h10, 8'h20); drive_b(0, 8'h30, 8'h70); tick();
    drive_a(1, 8'h10, 8'h20); drive_b(1, 8'h30, 8'h70); tick();
    a_valid = 1'b0; drive_b(2, 8'h30, 8'h70); tick();
    idle();
    check("part_valid", tile_valid, 1'b0);
    check("part_b_ready", b_ready, 1'b1);
    tile_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mrst_valid", tile_valid, 1'b0);
    check("mrst_a_ready", a_ready, 1'b1);
    check("mrst_b_ready", b_ready, 1'b1);
    check("mrst_A", o_A, '0);
    check("mrst_B", o_B, '0);
    check("mrst_SA", o_S_A, '0);
    check("mrst_SB", o_S_B, '0);
    for (int i = 0; i < 7; i++) begin
      drive_b(i, 8'h30, 8'h70);
      if (i < 4) drive_a(i, 8'h10, 8'h20);
      else a_valid = 1'b0;
      tick();
    end
    idle();
    check("t3_valid_7b", tile_valid, 1'b0);
    check("t3_a_ready", a_ready, 1'b0);
    check("t3_b_ready", b_ready, 1'b1);
    drive_b(7, 8'h30, 8'h70);
    tick();
    idle();
    check("t3_valid", tile_valid, 1'b1);
    build_exp(8'h10, 8'h20, 8'h30, 8'h70);
    check_tile("t3");
    tile_ready = 1'b1;
    tick();
    tile_ready = 1'b0;
    check("t3_hs_valid", tile_valid, 1'b0);

    // k=4 instance: B scales only from rows 0 and 4.
    for (int r = 0; r < 8; r++) begin
      k4_b_valid = 1'b1;
      for (int c = 0; c < int'(Y); c++) begin
        k4_b_row[c]   = 8'(2 * r + c);
        k4_s_b_row[c] = 8'(8'h40 + r);
      end
      k4_a_valid = (r < 4) ? 1'b1 : 1'b0;
      tick();
    end
    k4_a_valid = 1'b0;
    k4_b_valid = 1'b0;
    check("k4_valid", k4_tile_valid, 1'b1);
    check("k4_SB", k4_o_S_B, 32'h4444_4040);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/matmul_tile_loader.md
Name: matmul_tile_loader

Overview:
- Upstream staging buffer for matmul_fp.
- Accepts A rows (with their per-block A scales) and B rows (with per-block B scales) over two independent valid/ready streams.
- Assembles one complete tile: A [x_rows][vec_elem_count], B [vec_elem_count][y_cols], S_A [x_rows][block_count] and S_B [block_count][y_cols].
- Presents the tile as stable, registered arrays under a valid/ready handshake, wired straight to matmul_fp's A_i/B_i/S_A_i/S_B_i.

Parameters:
- x_rows, 4: number of A rows per tile.
- vec_elem_count, 8: A columns, equal to B rows.
- y_cols, 2: number of B columns per tile.
- k, 2: MX block size; must divide vec_elem_count.
- bit_width, 8: element width.
- scale_width, 8: shared-scale width.
- block_count, localparam: vec_elem_count/k.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_a_valid  in  1  A row beat valid.
- o_a_ready  out  1  A row beat accepted when valid&&ready.
- i_a_row  in  [vec_elem_count] x bit_width  one A row.
- i_s_a_row  in  [block_count] x scale_width  scales for that A row.
- i_b_valid  in  1  B row beat valid.
- o_b_ready  out  1  B row beat accepted when valid&&ready.
- i_b_row  in  [y_cols] x bit_width  one B row.
- i_s_b_row  in  [y_cols] x scale_width  scales of the block containing this B row.
- o_tile_valid  out  1  full tile present on the o_* arrays.
- i_tile_ready  in  1  consumer takes the tile.
- o_A  out  [x_rows][vec_elem_count] x bit_width  tile A.
- o_B  out  [vec_elem_count][y_cols] x bit_width  tile B.
- o_S_A  out  [x_rows][block_count] x scale_width  tile A scales.
- o_S_B  out  [block_count][y_cols] x scale_width  tile B scales.

Behaviour:
- Reset (i_rst_n=0 at an edge):
  - state=LOAD, a_cnt=0, b_cnt=0.
  - o_tile_valid=0, o_a_ready=1, o_b_ready=1.
  - o_A, o_B, o_S_A, o_S_B all cleared to 0.
  - Reset mid-load or mid-FULL discards all partial or pending data.
- States:
  - LOAD: collect beats.
  - FULL: present the tile.
- Ready generation:
  - o_a_ready = (state==LOAD) && (a_cnt < x_rows).
  - o_b_ready = (state==LOAD) && (b_cnt < vec_elem_count).
  - Readies are derived from registered state only; they never depend on the valid inputs.
- A accept: writes o_A[a_cnt] <= i_a_row and o_S_A[a_cnt] <= i_s_a_row, then a_cnt++.
- B accept:
  - Writes o_B[b_cnt] <= i_b_row.
  - If b_cnt % k == 0, also writes o_S_B[b_cnt/k] <= i_s_b_row; otherwise i_s_b_row is ignored.
  - Then b_cnt++.
- A and B streams are fully independent. Beats on both in the same cycle are both accepted. Arrival order between the streams is arbitrary.
- LOAD->FULL:
  - Taken when both counters are complete, counting any beats accepted in the current cycle.
  - o_tile_valid rises on the edge after the final accepted beat (1-cycle latency).
  - If both final beats land in the same cycle, the transition is the same single edge.
- FULL:
  - Both readies are 0.
  - o_* arrays are held bit-stable.
  - o_tile_valid stays 1 until i_tile_ready=1.
- FULL->LOAD:
  - Taken on the handshake edge; counters clear and o_tile_valid falls.
  - Readies reassert on the next cycle: exactly one bubble between tiles.
  - Array contents are not cleared; they are overwritten by the next tile.
- Ignored inputs:
  - i_tile_ready while in LOAD.
  - Valid inputs while the matching ready is 0.
- Counter widths: $clog2(x_rows+1) and $clog2(vec_elem_count+1). Counters saturate at full and never wrap.
- Elaboration error if vec_elem_count % k != 0.

Decomposition:
- Shared package mx_tile_pkg:
  - state enum {LOAD, FULL}.
  - Element and scale typedefs parameterised by bit_width and scale_width.
  - Helper function for the block index (row/k).
- One natural sub-module, tile_row_buffer:
  - Parameterised depth, row width and scale-write stride.
  - Contains the counter, ready logic and row/scale write enables.
  - Instantiated once for the A stream (stride 1) and once for the B stream (stride k).
- The top level holds the FSM and the tile handshake.

Test Plan:
- Defaults; reset; send A rows 0..3 with elements = 8*row + col and S_A = 16*row + blk; then send B rows 0..7 with B[r][c] = 2*r + c and S_B supplied per row = 0x40 + r -> tile_valid rises 1 cycle after the last B beat; o_A[2][5]=21; o_S_B = {0x40, 0x42, 0x44, 0x46}; odd-row scales ignored.
- Interleave A and B beats, with the last A and last B beats in the same cycle -> tile_valid is 1 on the next cycle; a_cnt=4, b_cnt=8 at that point; no extra beat is accepted.
- Hold i_tile_ready=0 for 10 cycles in FULL while driving both valids high with new data -> both readies stay 0; o_* arrays unchanged bit-for-bit.
- Pulse i_tile_ready for 1 cycle -> tile_valid=0 the next cycle; readies=1; a second tile loaded back-to-back completes; o_A[0][0] reflects the new value.
- Assert i_rst_n=0 for 1 cycle after 2 A and 3 B beats -> all outputs 0; a full tile then needs 4 A + 8 B fresh beats.
- Parameter sweep k=4, vec_elem_count=8 -> S_B captured only on B rows 0 and 4.
